hd44780_nybble_sender: RTL and testbench

Physical-layer stage directly downstream of `hd44780_controller`. It accepts one register-select bit and one byte per strobe and drives the 4-bit HD44780 bus (RS, E, D7..D4) with correct setup, enable-pulse, hold and inter-nybble timing. After the transfer it waits a per-transfer post-command delay, then deasserts `busy` so the controller can issue the next byte. R/~W is tied low at board level; this block never reads the LCD.

---
 rtl/hd44780_nybble_sender.sv | 210 +++++++++++++++++++++
 tb/tb_hd44780_nybble_sender.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_nybble_sender.sv
// hd44780_nybble_sender: drives the 4-bit HD44780 bus (RS, E, D7..D4)
// with setup, enable pulse, hold, inter-nybble gap and post delay.
module hd44780_nybble_sender #(
  parameter int SETUP_CYCLES  = 1,
  parameter int E_HIGH_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1,
  parameter int GAP_CYCLES    = 12,
  parameter int DELAY_W       = 16
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               STB_I,
  input  logic               i_rs,
  input  logic [7:0]         i_lcd_data,
  input  logic               i_single,
  input  logic [DELAY_W-1:0] i_post_delay,
  output logic               busy,
  output logic               o_rs,
  output logic [3:0]         o_lcd_data,
  output logic               o_e
);

  localparam int MAX_A =
    (SETUP_CYCLES > E_HIGH_CYCLES) ?
    SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_B =
    (HOLD_CYCLES > GAP_CYCLES) ?
    HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_P =
    (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PW = $clog2(MAX_P);
  localparam int CW =
    (DELAY_W > PW) ? DELAY_W : PW;

  localparam logic [CW-1:0] LD_S =
    CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_E =
    CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LD_H =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_G =
    CW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    SETUP_H,
    EHI_H,
    HOLD_H,
    GAP,
    SETUP_L,
    EHI_L,
    HOLD_L,
    POST
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rs_q, rs_d;
  logic [3:0]           dat_q, dat_d;
  logic [3:0]           lo_q, lo_d;
  logic                 single_q, single_d;
  logic [DELAY_W-1:0]   post_q, post_d;

  logic                 done;
  logic [CW-1:0]        cnt_dec;
  state_e               post_state;
  logic [CW-1:0]        post_ld;

  assign done    = (cnt_q == '0);
  assign cnt_dec = cnt_q - CW'(1);

  // A zero post delay skips POST entirely.
  assign post_state =
    (post_q == '0) ? IDLE : POST;
  assign post_ld =
    (post_q == '0) ? '0 :
    (CW'(post_q) - CW'(1));

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      dat_q    <= 4'h0;
      lo_q     <= 4'h0;
      single_q <= 1'b0;
      post_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      dat_q    <= dat_d;
      lo_q     <= lo_d;
      single_q <= single_d;
      post_q   <= post_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    dat_d    = dat_q;
    lo_d     = lo_q;
    single_d = single_q;
    post_d   = post_q;
    unique case (state_q)
      IDLE: begin
        if (STB_I) begin
          state_d  = SETUP_H;
          cnt_d    = LD_S;
          rs_d     = i_rs;
          dat_d    = i_lcd_data[7:4];
          lo_d     = i_lcd_data[3:0];
          single_d = i_single;
          post_d   = i_post_delay;
        end
      end
      SETUP_H: begin
        if (done) begin
          state_d = EHI_H;
          cnt_d   = LD_E;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      EHI_H: begin
        if (done) begin
          state_d = HOLD_H;
          cnt_d   = LD_H;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      HOLD_H: begin
        if (done) begin
          if (single_q) begin
            state_d = post_state;
            cnt_d   = post_ld;
          end else begin
            state_d = GAP;
            cnt_d   = LD_G;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      GAP: begin
        if (done) begin
          state_d = SETUP_L;
          cnt_d   = LD_S;
          dat_d   = lo_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      SETUP_L: begin
        if (done) begin
          state_d = EHI_L;
          cnt_d   = LD_E;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      EHI_L: begin
        if (done) begin
          state_d = HOLD_L;
          cnt_d   = LD_H;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      HOLD_L: begin
        if (done) begin
          state_d = post_state;
          cnt_d   = post_ld;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      POST: begin
        if (done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // E is decoded from the state flop so reset drops it at once.
  always_comb begin
    o_e  = 1'b0;
    busy = 1'b1;
    unique case (1'b1)
      (state_q == IDLE):  busy = 1'b0;
      (state_q == EHI_H): o_e  = 1'b1;
      (state_q == EHI_L): o_e  = 1'b1;
      default: ;
    endcase
  end

  assign o_rs       = rs_q;
  assign o_lcd_data = dat_q;

endmodule

// File: tb/tb_hd44780_nybble_sender.sv
// tb_hd44780_nybble_sender: table vectors, hand sequences and random
// transfers checked cycle by cycle against a timeline model.
module tb_hd44780_nybble_sender;

  localparam int S  = 1;
  localparam int EH = 3;
  localparam int H  = 1;
  localparam int G  = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  bit            clk_run = 1'b0;
  logic          RST_I, STB_I, i_rs, i_single;
  logic [7:0]    i_lcd_data;
  logic [DW-1:0] i_post_delay;
  logic          busy, o_rs, o_e;
  logic [3:0]    o_lcd_data;

  int checks   = 0;
  int failures = 0;

  hd44780_nybble_sender #(
    .SETUP_CYCLES (S),
    .E_HIGH_CYCLES(EH),
    .HOLD_CYCLES  (H),
    .GAP_CYCLES   (G),
    .DELAY_W      (DW)
  ) dut (
    .CLK_I       (clk),
    .RST_I       (RST_I),
    .STB_I       (STB_I),
    .i_rs        (i_rs),
    .i_lcd_data  (i_lcd_data),
    .i_single    (i_single),
    .i_post_delay(i_post_delay),
    .busy        (busy),
    .o_rs        (o_rs),
    .o_lcd_data  (o_lcd_data),
    .o_e         (o_e)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic       single;
    int         post;
    int         blen;
    int         np;
    logic [3:0] n0;
    logic [3:0] n1;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  function automatic int xfer_len(input bit single,
                                  input int post);
    return single ? (S + EH + H + post)
                  : (2 * (S + EH + H) + G + post);
  endfunction

  // Expected {busy, e, rs, data} k cycles after the accepting edge.
  function automatic logic [6:0] model(input int k,
                                       input bit rs,
                                       input logic [7:0] d,
                                       input bit single,
                                       input int post);
    int t2 = S + EH + H + G;
    bit b = (k < xfer_len(single, post));
    bit e = (k >= S && k < S + EH) ||
            (!single && k >= t2 + S && k < t2 + S + EH);
    logic [3:0] n = (!single && k >= t2) ? d[3:0] : d[7:4];
    return {b, e, rs, n};
  endfunction

  task automatic run_xfer(input bit rs,
                          input logic [7:0] d,
                          input bit single,
                          input int post,
                          input bit restb,
                          input bit rel,
                          output int blen,
                          output int np,
                          output logic [3:0] n0,
                          output logic [3:0] n1,
                          output int werr);
    int L = xfer_len(single, post);
    logic [6:0] act;
    logic [6:0] exp;
    bit pe = 1'b0;
    blen = 0;
    np   = 0;
    n0   = 4'h0;
    n1   = 4'h0;
    werr = 0;
    @(negedge clk);
    if (rel) RST_I = 1'b1;
    STB_I        = 1'b1;
    i_rs         = rs;
    i_lcd_data   = d;
    i_single     = single;
    i_post_delay = DW'(post);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      STB_I = restb && (k == 3);
      if (restb && k == 3) begin
        i_lcd_data   = 8'hFF;
        i_rs         = ~rs;
        i_single     = 1'b0;
        i_post_delay = '1;
      end
      act = {busy, o_e, o_rs, o_lcd_data};
      exp = model(k, rs, d, single, post);
      if (busy === 1'b1) blen++;
      if (o_e === 1'b1 && !pe) begin
        if (np == 0) n0 = o_lcd_data;
        else if (np == 1) n1 = o_lcd_data;
        np++;
      end
      pe = (o_e === 1'b1);
      if (act !== exp) werr++;
    end
    STB_I = 1'b0;
  endtask

  task automatic check_xfer(input string tag,
                            input bit rs,
                            input logic [7:0] d,
                            input bit single,
                            input int post,
                            input bit restb,
                            input bit rel);
    int blen, np, werr;
    logic [3:0] n0, n1;
    run_xfer(rs, d, single, post, restb, rel,
             blen, np, n0, n1, werr);
    chk({tag, "_wave"}, werr, 0);
    chk({tag, "_busy_len"}, blen, xfer_len(single, post));
    chk({tag, "_pulses"}, np, single ? 1 : 2);
    chk({tag, "_nyb_hi"}, n0, d[7:4]);
    if (!single) chk({tag, "_nyb_lo"}, n1, d[3:0]);
  endtask

  initial begin
    vec_t vecs[3];
    int blen, np, werr, bb_err, idle_err;
    logic [3:0] n0, n1;

    vecs[0] = '{rs: 1'b0, d: 8'h28, single: 1'b0, post: 444,
                blen: 466, np: 2, n0: 4'h2, n1: 4'h8};
    vecs[1] = '{rs: 1'b1, d: 8'h6D, single: 1'b0, post: 0,
                blen: 22, np: 2, n0: 4'h6, n1: 4'hD};
    vecs[2] = '{rs: 1'b0, d: 8'h30, single: 1'b1, post: 18240,
                blen: 18245, np: 1, n0: 4'h3, n1: 4'h0};

    RST_I        = 1'b0;
    STB_I        = 1'b0;
    i_rs         = 1'b0;
    i_lcd_data   = 8'h00;
    i_single     = 1'b0;
    i_post_delay = '0;

    #20;
    chk("reset_outputs", {busy, o_e, o_rs, o_lcd_data}, 0);
    clk_run = 1'b1;
    @(negedge clk);
    RST_I = 1'b1;
    idle_err = 0;
    repeat (10) begin
      @(negedge clk);
      if ({busy, o_e, o_rs, o_lcd_data} !== 7'd0) idle_err++;
    end
    chk("idle_after_reset", idle_err, 0);

    for (int i = 0; i < 3; i++) begin
      run_xfer(vecs[i].rs, vecs[i].d, vecs[i].single,
               vecs[i].post, (i == 0), 1'b0,
               blen, np, n0, n1, werr);
      chk($sformatf("vec%0d_wave", i), werr, 0);
      chk($sformatf("vec%0d_busy_len", i), blen, vecs[i].blen);
      chk($sformatf("vec%0d_pulses", i), np, vecs[i].np);
      chk($sformatf("vec%0d_nyb_hi", i), n0, vecs[i].n0);
      chk($sformatf("vec%0d_nyb_lo", i), n1, vecs[i].n1);
    end

    // Held strobe: exactly one idle cycle between transfers.
    @(negedge clk);
    STB_I        = 1'b1;
    i_rs         = 1'b1;
    i_lcd_data   = 8'hA5;
    i_single     = 1'b0;
    i_post_delay = '0;
    bb_err = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (busy !== (k != 22)) bb_err++;
    end
    STB_I = 1'b0;
    chk("b2b_busy_pattern", bb_err, 0);
    repeat (25) @(negedge clk);
    chk("b2b_second_done", busy, 0);

    // Reset while E is high.
    @(negedge clk);
    STB_I        = 1'b1;
    i_rs         = 1'b1;
    i_lcd_data   = 8'h3C;
    i_single     = 1'b0;
    i_post_delay = DW'(5);
    @(negedge clk);
    STB_I = 1'b0;
    @(negedge clk);
    chk("pulse_before_reset", o_e, 1);
    #2;
    RST_I = 1'b0;
    #1;
    chk("e_after_async_reset", o_e, 0);
    chk("busy_after_async_reset", busy, 0);
    chk("bus_after_async_reset", {o_rs, o_lcd_data}, 0);
    check_xfer("post_reset", 1'b1, 8'h9B, 1'b0, 7,
               1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      bit rs, single, restb;
      logic [7:0] d;
      int post;
      rs     = 1'($urandom_range(0, 1));
      single = ($urandom_range(0, 3) == 0);
      restb  = 1'($urandom_range(0, 1));
      d      = 8'($urandom);
      post   = int'($urandom_range(0, 30));
      check_xfer($sformatf("rnd%0d", i), rs, d, single,
                 post, restb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
